// File: rtl/axis_frame_gen.sv
// AXI-Stream pattern source: emits a run of fixed-length frames with an
// incrementing data word, optional idle gaps between frames and a graceful stop.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_count,
    input  logic [LEN_WIDTH-1:0]  cfg_gap,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frames_sent
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                state_q,   state_d;
    logic [LEN_WIDTH-1:0]  len_q,     len_d;
    logic [LEN_WIDTH-1:0]  gap_q,     gap_d;
    logic [LEN_WIDTH-1:0]  beat_q,    beat_d;
    logic [LEN_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]  count_q,   count_d;
    logic [CNT_WIDTH-1:0]  frames_q,  frames_d;
    logic [DATA_WIDTH-1:0] tdata_q,   tdata_d;
    logic                  tvalid_q,  tvalid_d;
    logic                  tlast_q,   tlast_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  stop_q,    stop_d;

    logic                  xfer_s;
    logic                  stop_pend_s;
    logic [LEN_WIDTH-1:0]  len_in_s;
    logic [LEN_WIDTH-1:0]  beat_next_s;
    logic [CNT_WIDTH-1:0]  frames_next_s;

    // A zero-length request is promoted to a single-beat frame at latch time.
    assign len_in_s      = (cfg_frame_len == '0) ? LEN_ONE : cfg_frame_len;
    assign xfer_s        = tvalid_q & m_axis_tready;
    assign stop_pend_s   = stop_q | stop;
    assign beat_next_s   = beat_q + LEN_ONE;
    assign frames_next_s = frames_q + CNT_WIDTH'(1);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        gap_d     = gap_q;
        beat_d    = beat_q;
        gap_cnt_d = gap_cnt_q;
        count_d   = count_q;
        frames_d  = frames_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        stop_d    = stop_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = len_in_s;
                    count_d   = cfg_frame_count;
                    gap_d     = cfg_gap;
                    frames_d  = '0;
                    stop_d    = 1'b0;
                    tdata_d   = cfg_seed;
                    beat_d    = LEN_ONE;
                    gap_cnt_d = '0;
                    busy_d    = 1'b1;
                    if (cfg_frame_count == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_SEND;
                        tvalid_d = 1'b1;
                        tlast_d  = (len_in_s == LEN_ONE);
                    end
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_SEND: begin
                stop_d = stop_pend_s;
                if (xfer_s) begin
                    tdata_d = tdata_q + DATA_WIDTH'(1);
                    if (tlast_q) begin
                        frames_d = frames_next_s;
                        if ((frames_next_s == count_q) || stop_pend_s) begin
                            state_d  = ST_FIN;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            done_d   = 1'b1;
                        end else if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_cnt_d = gap_q;
                        end else begin
                            beat_d  = LEN_ONE;
                            tlast_d = (len_q == LEN_ONE);
                        end
                    end else begin
                        beat_d  = beat_next_s;
                        tlast_d = (beat_next_s == len_q);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                stop_d = stop_pend_s;
                if (stop_pend_s) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else if (gap_cnt_q <= LEN_ONE) begin
                    state_d   = ST_SEND;
                    tvalid_d  = 1'b1;
                    beat_d    = LEN_ONE;
                    tlast_d   = (len_q == LEN_ONE);
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_ONE;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                stop_d  = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
                stop_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            gap_q     <= '0;
            beat_q    <= '0;
            gap_cnt_q <= '0;
            count_q   <= '0;
            frames_q  <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            beat_q    <= beat_d;
            gap_cnt_q <= gap_cnt_d;
            count_q   <= count_d;
            frames_q  <= frames_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stop_q    <= stop_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frames_sent   = frames_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: runs push expected beats and done events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_axis_frame_gen;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic [LW-1:0] cfg_frame_len;
    logic [CW-1:0] cfg_frame_count;
    logic [LW-1:0] cfg_gap;
    logic [DW-1:0] cfg_seed;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic [CW-1:0] frames_sent;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct {
        int frames;
        bit lat;
    } done_t;

    beat_t exp_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    failures = 0;
    int    done_seen = 0;
    int    cyc = 0;
    int    last_xfer_cyc = 0;
    int    idle_cnt = 0;
    bit    rand_ready = 1'b0;

    axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .cfg_frame_len   (cfg_frame_len),
        .cfg_frame_count (cfg_frame_count),
        .cfg_gap         (cfg_gap),
        .cfg_seed        (cfg_seed),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .busy            (busy),
        .done            (done),
        .frames_sent     (frames_sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    // Sink ready: always 1 unless the random-backpressure phase is enabled.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare transfers, stalls, gaps and done events against the scoreboard.
    initial begin
        beat_t         e;
        done_t         dn;
        logic          stall_pend;
        logic [DW-1:0] stall_data;
        logic          stall_last;
        logic          done_prev;
        stall_pend = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        done_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_pend = 1'b0;
                done_prev  = 1'b0;
                idle_cnt   = 0;
            end else begin
                cyc++;
                if (stall_pend)
                    chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                        {1'b1, stall_last, stall_data});
                if (done_prev)
                    chk("done_one_cycle", done, 1'b0);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", m_axis_tdata, e.data);
                        chk("tlast", m_axis_tlast, e.last);
                        if (e.gap >= 0)
                            chk("idle_cycles_before_beat", idle_cnt, e.gap);
                    end
                    idle_cnt = 0;
                    if (m_axis_tlast)
                        last_xfer_cyc = cyc;
                end else if (!m_axis_tvalid) begin
                    idle_cnt++;
                end
                if (done) begin
                    done_seen++;
                    chk("busy_with_done", busy, 1'b1);
                    if (done_q.size() == 0) begin
                        fail_now("unexpected_done", frames_sent);
                    end else begin
                        dn = done_q.pop_front();
                        chk("frames_sent_at_done", frames_sent, dn.frames);
                        chk("beats_before_done", exp_q.size(), 0);
                        if (dn.lat)
                            chk("done_latency", cyc - last_xfer_cyc, 1);
                    end
                end
                stall_pend = m_axis_tvalid && !m_axis_tready;
                stall_data = m_axis_tdata;
                stall_last = m_axis_tlast;
                done_prev  = done;
            end
        end
    end

    task automatic run(input int len, input int cnt, input int gap, input logic [DW-1:0] seed,
                       input int exp_frames, input bit ss, input bit use_stop,
                       input logic [DW-1:0] stop_data, input logic stop_valid, input bit lat);
        int            alen;
        int            g;
        int            d0;
        bit            hit;
        logic [DW-1:0] d;
        alen = (len == 0) ? 1 : len;
        d = seed;
        for (int f = 0; f < exp_frames; f++) begin
            for (int b = 1; b <= alen; b++) begin
                g = (b != 1) ? 0 : ((f == 0) ? -1 : gap);
                exp_q.push_back('{d, (b == alen), g});
                d = d + 32'd1;
            end
        end
        done_q.push_back('{exp_frames, lat});
        d0 = done_seen;
        @(posedge clk);
        #1;
        cfg_frame_len   = LW'(len);
        cfg_frame_count = CW'(cnt);
        cfg_gap         = LW'(gap);
        cfg_seed        = seed;
        start           = 1'b1;
        stop            = ss;
        @(posedge clk);
        #1;
        start           = 1'b0;
        stop            = 1'b0;
        cfg_frame_len   = 16'd7;
        cfg_frame_count = 16'd9;
        cfg_gap         = 16'd3;
        cfg_seed        = 32'hDEAD0000;
        @(negedge clk);
        chk("tvalid_after_start", m_axis_tvalid, (cnt != 0));
        chk("busy_after_start", busy, 1'b1);
        @(posedge clk);
        #1;
        if (alen * exp_frames >= 4) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (use_stop) begin
            hit = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (m_axis_tvalid === stop_valid && m_axis_tdata === stop_data) begin
                    hit = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk("stop_point_reached", hit, 1'b1);
            stop = 1'b1;
            @(posedge clk);
            #1;
            stop = 1'b0;
        end
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_seen > d0) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("done_seen", hit, 1'b1);
        @(posedge clk);
        #1;
        chk("idle_after_run", {busy, m_axis_tvalid}, 2'b00);
        chk("frames_sent_hold", frames_sent, exp_frames);
        chk("beats_left", exp_q.size(), 0);
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        stop            = 1'b0;
        cfg_frame_len   = '0;
        cfg_frame_count = '0;
        cfg_gap         = '0;
        cfg_seed        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {m_axis_tvalid, m_axis_tlast, busy, done}, 4'b0000);
        chk("reset_tdata", m_axis_tdata, 32'h0);
        chk("reset_frames", frames_sent, 16'h0);
        rst = 1'b0;

        run(4, 2, 0, 32'h10, 2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        run(3, 2, 2, 32'h20, 2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        rand_ready = 1'b1;
        run(5, 3, 1, 32'h100, 3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rand_ready = 1'b0;
        run(4, 1, 0, 32'hFFFFFFFE, 1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        run(4, 5, 0, 32'h40, 2, 1'b0, 1'b1, 32'h45, 1'b1, 1'b1);
        run(2, 2, 0, 32'h60, 2, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++)
            exp_q.push_back('{32'h80 + 32'(i), (i == 7), (i == 0) ? -1 : 0});
        @(posedge clk);
        #1;
        cfg_frame_len   = 16'd8;
        cfg_frame_count = 16'd1;
        cfg_gap         = 16'd0;
        cfg_seed        = 32'h80;
        start           = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midframe_tdata", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h83});
        rst = 1'b1;
        #1;
        chk("rst_async_ctrl", {m_axis_tvalid, m_axis_tlast, busy, done}, 4'b0000);
        chk("rst_async_tdata", m_axis_tdata, 32'h0);
        chk("rst_async_frames", frames_sent, 16'h0);
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_restart_after_rst", {busy, m_axis_tvalid}, 2'b00);

        run(4, 0, 0, 32'h70, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        run(0, 3, 0, 32'h90, 3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        run(2, 3, 5, 32'hA0, 1, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen.md
AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of tdata in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, meaning the width of the frame length and gap fields.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the frame count field.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; all other ports are synchronous to clk.
REQ-005 clk  input  1  clock; all flops update on the rising edge.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 start  input  1  launches a run; sampled only in IDLE.
REQ-008 stop  input  1  graceful stop request; sampled while busy.
REQ-009 cfg_frame_len  input  LEN_WIDTH  beats per frame.
REQ-010 cfg_frame_count  input  CNT_WIDTH  frames per run.
REQ-011 cfg_gap  input  LEN_WIDTH  idle cycles between frames.
REQ-012 cfg_seed  input  DATA_WIDTH  tdata value of the first beat.
REQ-013 m_axis_tdata  output  DATA_WIDTH  stream data.
REQ-014 m_axis_tvalid  output  1  stream valid.
REQ-015 m_axis_tready  input  1  sink ready.
REQ-016 m_axis_tlast  output  1  last beat of a frame.
REQ-017 busy  output  1  run in progress.
REQ-018 done  output  1  one-cycle pulse at the end of a run.
REQ-019 frames_sent  output  CNT_WIDTH  count of completed frames in the current or last run.

Function
REQ-020 SHALL implement the states IDLE, SEND, GAP and FIN.
REQ-021 IDLE with start=1: SHALL latch all cfg_* inputs, clear frames_sent, and go to SEND; tvalid rises the next cycle. cfg_* changes after the latch are ignored.
REQ-022 SHALL treat a latched frame_len of 0 as 1 beat.
REQ-023 SHALL go from IDLE to FIN with no beats when the latched frame_count is 0.
REQ-024 SEND: SHALL hold tvalid=1; a beat transfers on any cycle with tvalid && tready.
REQ-025 SHALL hold tdata and tlast stable while tvalid=1 and tready=0, and SHALL never drop tvalid without a transfer (except on reset).
REQ-026 tdata SHALL start at the seed and increment by 1 per transferred beat, modulo 2^DATA_WIDTH, continuing across frame boundaries without reset.
REQ-027 tlast SHALL be 1 exactly on beat frame_len of each frame.
REQ-028 On the tlast transfer, frames_sent SHALL increment by 1 in the same cycle.
REQ-029 After the tlast transfer with more frames pending and no stop: SHALL go to GAP if gap>0, otherwise stay in SEND with the next frame's first beat valid the following cycle (back-to-back).
REQ-030 GAP: SHALL hold tvalid=0 for exactly gap cycles, then return to SEND.
REQ-031 After the tlast transfer of the final frame, or with a stop request pending, SHALL go to FIN.
REQ-032 stop SHALL be sticky once seen while busy, SHALL never truncate a frame, and SHALL take effect at the next tlast transfer.
REQ-033 stop seen in GAP SHALL cause an immediate transition to FIN.
REQ-034 FIN: SHALL assert done=1 for one cycle, then go to IDLE.
REQ-035 busy SHALL be 1 in SEND, GAP and FIN, and 0 in IDLE.
REQ-036 start SHALL be ignored while busy.
REQ-037 start and stop in the same IDLE cycle: SHALL start the run; stop is not sampled in IDLE.
REQ-038 frames_sent SHALL hold its value in IDLE until the next start.
REQ-039 Internal beat and gap counters SHALL be LEN_WIDTH bits wide; the frame counter SHALL be CNT_WIDTH bits wide; none of them wrap.

Reset
REQ-040 rst=1 SHALL immediately force state IDLE, with tvalid=0, tlast=0, tdata=0, busy=0, done=0, frames_sent=0, and all latched configuration cleared.
REQ-041 Reset mid-frame SHALL abort the frame with no further beats; a truncated frame is accepted behaviour.
REQ-042 After rst deasserts, the block SHALL require a fresh start.

Verification
REQ-043 len=4, count=2, gap=0, seed=0x10, tready=1: 8 consecutive beats with tdata 0x10..0x17 and tlast on 0x13 and 0x17; done pulses 1 cycle after 0x17; frames_sent=2.
REQ-044 len=3, count=2, gap=2: exactly 2 idle cycles between the beat 0x..2 tlast and the next beat; tdata continues incrementing across the gap.
REQ-045 Random tready (50%): tdata and tlast are stable during every stall, no beat is lost or duplicated, and the total beat count is len*count.
REQ-046 seed=0xFFFFFFFE, len=4: tdata sequence FFFFFFFE, FFFFFFFF, 0, 1.
REQ-047 count=5, len=4, stop pulsed on beat 2 of frame 2: frame 2 completes, frames_sent=2, done pulses, and no beats follow.
REQ-048 rst asserted mid-frame: tvalid=0 immediately and all outputs at reset values; count=0 after a fresh start gives done with no beats; len=0 gives 1-beat frames with tlast=1.
